sd_spi_cmd_host: RTL

Host-side SPI engine that issues one SD command frame and collects the card's R1 response. Runs on the system clock and derives sclk internally. Drives cs_n, sclk and mosi; samples miso. It is the initiator paired with the SPI-mode card model, and sits between the controller's init/command sequencer and the card pins.

---
 rtl/sd_pkg.sv | 51 +++++
 rtl/sd_spi_byte_xfer.sv | 66 ++++++
 rtl/sd_spi_cmd_host.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared constants, FSM state type and frame helpers for the SD SPI command host.
package sd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] R1_IDLE        = 8'h01;
    localparam int         SD_FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_POLL,
        ST_TRAIL,
        ST_DONE
    } sd_state_e;

    // Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, seed zero.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [5:0]  index,
                                              input logic [31:0] arg);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {2'b01, index};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            3'd5:    b = {crc7({2'b01, index, arg}), 1'b1};
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte_xfer.sv
// One-byte full-duplex SPI mode-0 shifter. A go pulse in the byte_done cycle
// chains the next byte with no gap on sclk.
module sd_spi_byte_xfer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       r_active;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic       r_sclk;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       w_phase_end;

    assign w_phase_end = r_active && (r_cnt == DIV_LAST);
    assign byte_done   = w_phase_end && r_sclk && (r_bit == 3'd7);
    assign sclk        = r_sclk;
    assign mosi        = r_tx[7];
    assign rx          = r_rx;

    // Ones shift in behind the data, so mosi rests high once a byte completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd0;
            r_sclk   <= 1'b0;
            r_tx     <= 8'hFF;
            r_rx     <= 8'hFF;
        end else if (go) begin
            r_active <= 1'b1;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd0;
            r_sclk   <= 1'b0;
            r_tx     <= tx;
        end else if (w_phase_end) begin
            r_cnt <= 8'd0;
            if (!r_sclk) begin
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[6:0], miso};
            end else begin
                r_sclk <= 1'b0;
                r_bit  <= r_bit + 3'd1;
                r_tx   <= {r_tx[6:0], 1'b1};
                if (r_bit == 3'd7) begin
                    r_active <= 1'b0;
                end
            end
        end else if (r_active) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sd_spi_cmd_host.sv
// SD SPI-mode command host: sends one 6-byte command frame, polls for R1,
// clocks one trailing byte, then reports resp/timeout with a done pulse.
module sd_spi_cmd_host
    import sd_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [15:0] POLL_LAST = 16'(NCR_MAX);
    localparam logic [2:0]  IDX_LAST  = 3'(SD_FRAME_BYTES - 1);

    sd_state_e   r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_poll;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic [7:0]  r_resp;
    logic        r_timeout;

    sd_state_e   w_state_next;
    logic [2:0]  w_idx_next;
    logic [15:0] w_poll_next;
    logic [5:0]  w_cmd_index_next;
    logic [31:0] w_cmd_arg_next;
    logic [7:0]  w_resp_next;
    logic        w_timeout_next;
    logic        w_go;
    logic [7:0]  w_tx;
    logic [7:0]  w_rx;
    logic        w_byte_done;
    logic        w_busy;
    logic        w_done;

    sd_spi_byte_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_go),
        .tx       (w_tx),
        .rx       (w_rx),
        .byte_done(w_byte_done),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_poll      <= 16'd0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'd0;
            r_resp      <= 8'hFF;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_poll      <= w_poll_next;
            r_cmd_index <= w_cmd_index_next;
            r_cmd_arg   <= w_cmd_arg_next;
            r_resp      <= w_resp_next;
            r_timeout   <= w_timeout_next;
        end
    end

    // Every byte is launched in the cycle the previous one finishes, keeping sclk gapless.
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_poll_next      = r_poll;
        w_cmd_index_next = r_cmd_index;
        w_cmd_arg_next   = r_cmd_arg;
        w_resp_next      = r_resp;
        w_timeout_next   = r_timeout;
        w_go             = 1'b0;
        w_tx             = 8'hFF;
        w_busy           = 1'b0;
        w_done           = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_done       = (r_state == ST_DONE);
                w_state_next = ST_IDLE;
                if (start) begin
                    w_state_next     = ST_SEND;
                    w_idx_next       = 3'd0;
                    w_cmd_index_next = cmd_index;
                    w_cmd_arg_next   = cmd_arg;
                    w_resp_next      = 8'hFF;
                    w_timeout_next   = 1'b0;
                    w_go             = 1'b1;
                    w_tx             = {2'b01, cmd_index};
                end
            end
            ST_SEND: begin
                w_busy = 1'b1;
                if (w_byte_done) begin
                    w_go = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = ST_POLL;
                        w_poll_next  = 16'd1;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                        w_tx       = frame_byte(r_idx + 3'd1, r_cmd_index, r_cmd_arg);
                    end
                end
            end
            ST_POLL: begin
                w_busy = 1'b1;
                if (w_byte_done) begin
                    w_go = 1'b1;
                    if (!w_rx[7]) begin
                        w_resp_next  = w_rx;
                        w_state_next = ST_TRAIL;
                    end else if (r_poll == POLL_LAST) begin
                        w_timeout_next = 1'b1;
                        w_resp_next    = 8'hFF;
                        w_state_next   = ST_TRAIL;
                    end else begin
                        w_poll_next = r_poll + 16'd1;
                    end
                end
            end
            ST_TRAIL: begin
                w_busy = 1'b1;
                if (w_byte_done) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign cs_n    = !w_busy;
    assign resp    = r_resp;
    assign timeout = r_timeout;

endmodule
